// File: rtl/mdclcg_lcg_pair.sv
// mdclcg_lcg_pair: dual linear congruential generator feeding the MDCLCG
// magnitude comparator (a1_out -> a1, b1_out -> b1). Each accepted output
// pair advances both generators by one step; out_ready can stall the stream.
// Optional feature macro: MDCLCG_SAMPLE_COUNT_EN adds the 32-bit
// accepted-pair counter on sample_count (otherwise tied to zero).
module mdclcg_lcg_pair #(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] MULT_A = 64'd6364136223846793005,
    parameter logic [WIDTH-1:0] INC_A  = 64'd1442695040888963407,
    parameter logic [WIDTH-1:0] MULT_B = 64'd2862933555777941757,
    parameter logic [WIDTH-1:0] INC_B  = 64'd3037000493
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] a1_out,
    output logic [WIDTH-1:0] b1_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [31:0]      sample_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEDED = 2'd1,
        PRIME  = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] a_step_s;
    logic [WIDTH-1:0] b_step_s;
    logic             valid_r;
    logic             busy_r;
    logic             handshake_s;
    logic             count_inc_s;
    logic             count_clr_s;

    // One LCG step; product and sum are both truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] lcg_step(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] mult,
        input logic [WIDTH-1:0] inc
    );
        logic [WIDTH-1:0] prod;
        prod = mult * x;
        return prod + inc;
    endfunction

    assign a_step_s    = lcg_step(a_r, MULT_A, INC_A);
    assign b_step_s    = lcg_step(b_r, MULT_B, INC_B);
    // valid_r is only ever set in RUN, so this is the RUN-state handshake.
    assign handshake_s = valid_r & out_ready;

    // Next-state, next-register and counter-control decode.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        b_s         = b_r;
        count_inc_s = 1'b0;
        count_clr_s = 1'b0;
        if (seed_load) begin
            // Reseed wins over stop/start and swallows any handshake.
            state_s     = SEEDED;
            a_s         = seed_a;
            b_s         = seed_b;
            count_clr_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                SEEDED: begin
                    if (start) begin
                        state_s = PRIME;
                    end else begin
                        state_s = SEEDED;
                    end
                end
                PRIME: begin
                    // The priming step always applies so the seed is never emitted.
                    a_s = a_step_s;
                    b_s = b_step_s;
                    if (stop) begin
                        state_s = SEEDED;
                    end else begin
                        state_s = RUN;
                    end
                end
                RUN: begin
                    if (handshake_s) begin
                        a_s         = a_step_s;
                        b_s         = b_step_s;
                        count_inc_s = 1'b1;
                    end else begin
                        a_s = a_r;
                        b_s = b_r;
                    end
                    if (stop) begin
                        state_s = SEEDED;
                    end else begin
                        state_s = RUN;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, generator registers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            valid_r <= (state_s == RUN);
            busy_r  <= (state_s == PRIME) || (state_s == RUN);
        end
    end

    assign a1_out    = a_r;
    assign b1_out    = b_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;

`ifdef MDCLCG_SAMPLE_COUNT_EN
    logic [31:0] count_r;

    // Accepted-pair counter; wraps naturally, cleared by reset or reseed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (count_clr_s) begin
            count_r <= 32'd0;
        end else if (count_inc_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign sample_count = count_r;
`else
    logic unused_count_ctrl_s;
    assign unused_count_ctrl_s = count_inc_s ^ count_clr_s;
    assign sample_count        = 32'd0;
`endif

endmodule

// File: tb/tb_mdclcg_lcg_pair.sv
// Self-checking bench for mdclcg_lcg_pair using a queue scoreboard of
// expected (a,b) pairs driven by an independent software LCG model.
module tb_mdclcg_lcg_pair;

    localparam longint unsigned MA = 64'd6364136223846793005;
    localparam longint unsigned IA = 64'd1442695040888963407;
    localparam longint unsigned MB = 64'd2862933555777941757;
    localparam longint unsigned IB = 64'd3037000493;
`ifdef MDCLCG_SAMPLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [63:0] seed_a;
    logic [63:0] seed_b;
    logic        start;
    logic        stop;
    logic [63:0] a1_out;
    logic [63:0] b1_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [31:0] sample_count;

    int              errors = 0;
    int              checks = 0;
    longint unsigned ma;
    longint unsigned mb;
    logic [31:0]     exp_cnt;
    logic [127:0]    sb_q[$];

    always #5 clk = ~clk;

    mdclcg_lcg_pair dut (
        .clk          (clk),
        .rst          (rst),
        .seed_load    (seed_load),
        .seed_a       (seed_a),
        .seed_b       (seed_b),
        .start        (start),
        .stop         (stop),
        .a1_out       (a1_out),
        .b1_out       (b1_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .sample_count (sample_count)
    );

    function automatic longint unsigned step_a(input longint unsigned x);
        return x * MA + IA;
    endfunction

    function automatic longint unsigned step_b(input longint unsigned x);
        return x * MB + IB;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seeds(input longint unsigned sa, input longint unsigned sb);
        seed_a    = sa;
        seed_b    = sb;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        ma        = sa;
        mb        = sb;
        exp_cnt   = 32'd0;
        sb_q.delete();
    endtask

    // start -> PRIME at the first edge, first pair visible after the second.
    task automatic start_run(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_prime: busy=%b valid=%b expected busy=1 valid=0", tag, busy, out_valid);
        end
        ma = step_a(ma);
        mb = step_b(mb);
        sb_q.delete();
        sb_q.push_back({ma, mb});
        tick();
        checks++;
        if ({a1_out, b1_out} !== sb_q[0] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_first: a=%0d b=%0d valid=%b expected a=%0d b=%0d valid=1",
                     tag, a1_out, b1_out, out_valid, sb_q[0][127:64], sb_q[0][63:0]);
        end
    endtask

    // Run n RUN-state cycles with out_ready fixed at rdy, checking each cycle.
    task automatic run_cycles(input string tag, input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            out_ready = rdy;
            if (rdy) begin
                void'(sb_q.pop_front());
                ma = step_a(ma);
                mb = step_b(mb);
                sb_q.push_back({ma, mb});
                exp_cnt = exp_cnt + 32'd1;
            end
            tick();
            checks++;
            if ({a1_out, b1_out} !== sb_q[0]) begin
                errors++;
                $display("FAIL %s_data[%0d]: a=%0d b=%0d expected a=%0d b=%0d",
                         tag, i, a1_out, b1_out, sb_q[0][127:64], sb_q[0][63:0]);
            end
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_flags[%0d]: valid=%b busy=%b expected 1/1", tag, i, out_valid, busy);
            end
            checks++;
            if (sample_count !== (CNT_EN ? exp_cnt : 32'd0)) begin
                errors++;
                $display("FAIL %s_count[%0d]: got %0d expected %0d",
                         tag, i, sample_count, (CNT_EN ? exp_cnt : 32'd0));
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (a1_out !== 64'd0 || b1_out !== 64'd0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || sample_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: a=%0d b=%0d valid=%b busy=%b cnt=%0d expected all 0",
                     a1_out, b1_out, out_valid, busy, sample_count);
        end
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (a1_out !== 64'd0 || b1_out !== 64'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_start_ignored: a=%0d b=%0d valid=%b busy=%b expected 0/0/0/0",
                     a1_out, b1_out, out_valid, busy);
        end
    endtask

    task automatic test_zero_seed();
        load_seeds(64'd0, 64'd0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || a1_out !== 64'd0 || b1_out !== 64'd0) begin
            errors++;
            $display("FAIL seeded_hold: a=%0d b=%0d valid=%b busy=%b expected 0/0/0/0",
                     a1_out, b1_out, out_valid, busy);
        end
        out_ready = 1'b1;
        start_run("zero_seed");
        checks++;
        if (a1_out !== 64'd1442695040888963407 || b1_out !== 64'd3037000493) begin
            errors++;
            $display("FAIL zero_seed_const: a=%0d b=%0d expected 1442695040888963407/3037000493",
                     a1_out, b1_out);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_unit_seed();
        load_seeds(64'd1, 64'h0123_4567_89AB_CDEF);
        start_run("unit_seed");
        checks++;
        if (a1_out !== 64'd7806831264735756412) begin
            errors++;
            $display("FAIL unit_seed_const: a=%0d expected 7806831264735756412", a1_out);
        end
        run_cycles("unit_stream", 8, 1'b1);
        checks++;
        if (sample_count !== (CNT_EN ? 32'd8 : 32'd0)) begin
            errors++;
            $display("FAIL unit_count8: got %0d expected %0d", sample_count, (CNT_EN ? 32'd8 : 32'd0));
        end
    endtask

    task automatic test_backpressure();
        run_cycles("bp_hold", 5, 1'b0);
        run_cycles("bp_resume", 3, 1'b1);
    endtask

    task automatic test_stop_collision();
        longint unsigned last_a;
        last_a    = ma;
        out_ready = 1'b1;
        stop      = 1'b1;
        void'(sb_q.pop_front());
        ma      = step_a(ma);
        mb      = step_b(mb);
        exp_cnt = exp_cnt + 32'd1;
        tick();
        stop      = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || a1_out !== ma || b1_out !== mb) begin
            errors++;
            $display("FAIL stop_collision: a=%0d b=%0d valid=%b busy=%b expected a=%0d b=%0d valid=0 busy=0",
                     a1_out, b1_out, out_valid, busy, ma, mb);
        end
        checks++;
        if (sample_count !== (CNT_EN ? exp_cnt : 32'd0)) begin
            errors++;
            $display("FAIL stop_count: got %0d expected %0d", sample_count, (CNT_EN ? exp_cnt : 32'd0));
        end
        start_run("after_stop");
        checks++;
        if (a1_out !== step_a(step_a(last_a))) begin
            errors++;
            $display("FAIL after_stop_skip: a=%0d expected %0d", a1_out, step_a(step_a(last_a)));
        end
        run_cycles("after_stop_stream", 2, 1'b1);
    endtask

    task automatic test_stop_in_prime();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        sb_q.delete();
        load_seeds(64'd77, 64'd99);
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        ma   = step_a(ma);
        mb   = step_b(mb);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || a1_out !== ma || b1_out !== mb) begin
            errors++;
            $display("FAIL stop_in_prime: a=%0d b=%0d valid=%b busy=%b expected a=%0d b=%0d 0/0",
                     a1_out, b1_out, out_valid, busy, ma, mb);
        end
        start_run("after_prime_stop");
        run_cycles("after_prime_stream", 2, 1'b1);
    endtask

    task automatic test_reseed_mid_run();
        out_ready = 1'b1;
        load_seeds(64'd0, 64'd0);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || a1_out !== 64'd0 ||
            b1_out !== 64'd0 || sample_count !== 32'd0) begin
            errors++;
            $display("FAIL reseed_mid_run: a=%0d b=%0d valid=%b busy=%b cnt=%0d expected all 0",
                     a1_out, b1_out, out_valid, busy, sample_count);
        end
        start_run("reseed");
        checks++;
        if (a1_out !== 64'd1442695040888963407) begin
            errors++;
            $display("FAIL reseed_const: a=%0d expected 1442695040888963407", a1_out);
        end
        run_cycles("reseed_stream", 3, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        seed_load = 1'b0;
        seed_a    = 64'd0;
        seed_b    = 64'd0;
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;
        ma        = 64'd0;
        mb        = 64'd0;
        exp_cnt   = 32'd0;
        test_reset();
        test_zero_seed();
        test_unit_seed();
        test_backpressure();
        test_stop_collision();
        test_stop_in_prime();
        test_reseed_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdclcg_lcg_pair.md
# mdclcg_lcg_pair

Dual linear congruential generator stage that produces the two 64-bit operand streams consumed by the MDCLCG magnitude comparator. It sits directly upstream of the comparator: `a1_out` and `b1_out` drive the comparator's `a1` and `b1` inputs. Each accepted output pair advances both LCGs by exactly one step. A valid/ready handshake lets the downstream bit-collection logic stall the generator.

## Interface
- `WIDTH`, 64: state and output width; arithmetic is mod 2^WIDTH.
- `MULT_A`, 64'd6364136223846793005: LCG A multiplier.
- `INC_A`, 64'd1442695040888963407: LCG A increment.
- `MULT_B`, 64'd2862933555777941757: LCG B multiplier.
- `INC_B`, 64'd3037000493: LCG B increment.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seed_load` in 1: one-cycle strobe; captures `seed_a`/`seed_b`.
- `seed_a` in WIDTH: seed for LCG A.
- `seed_b` in WIDTH: seed for LCG B.
- `start` in 1: begin generation (honoured only in SEEDED).
- `stop` in 1: pause generation (honoured only in PRIME/RUN).
- `a1_out` out WIDTH: current LCG A value (registered).
- `b1_out` out WIDTH: current LCG B value (registered).
- `out_valid` out 1: output pair valid.
- `out_ready` in 1: downstream accepts the pair.
- `busy` out 1: high in PRIME or RUN.
- `sample_count` out 32: number of accepted pairs (see Configuration).

## Operation
- States: IDLE, SEEDED, PRIME, RUN.
- Step function: x' = (MULT*x + INC) mod 2^WIDTH, computed for A and B in parallel in one cycle. Keep only the low WIDTH bits of the product; the carry out of the add is discarded.
- IDLE:
  - `seed_load` → SEEDED, state regs ← seeds.
  - `start` is ignored.
- SEEDED:
  - `start` → PRIME.
  - The state regs hold the seeds; `out_valid` = 0.
- PRIME:
  - Both regs ← step(regs), so the seed itself is never emitted.
  - Next state is RUN.
- RUN:
  - `out_valid` = 1.
  - On `out_valid && out_ready`, both regs ← step(regs) and `sample_count` increments.
  - Without the handshake, the regs and outputs hold stable.
- Priority, highest first: `rst` > `seed_load` > `stop` > `start`.
- `seed_load` in any state, including mid-RUN:
  - Reloads the regs and moves to SEEDED.
  - `out_valid` drops at the next edge.
  - A handshake in that same cycle is not counted and does not advance.
- `stop` in RUN:
  - If a handshake occurs in the same cycle, it completes: the regs advance and the count increments.
  - Next state is SEEDED and the regs are retained.
  - A later `start` passes through PRIME, so one value is skipped relative to an unstopped run.
- `stop` in PRIME: next state is SEEDED; the PRIME step still applies.
- Wrap-around: the state wraps naturally mod 2^WIDTH. `sample_count` wraps 0xFFFFFFFF → 0.

## Timing
- Reset values:
  - State is IDLE.
  - `a1_out`, `b1_out`, `out_valid`, `busy` and `sample_count` are all 0.
- Latency from `start` sampled at edge T: PRIME is entered at T; at T+1 the regs hold x1 and `out_valid` = 1.
- Throughput is one pair per cycle while `out_ready` is held high.
- Outputs come directly from registers; there is no combinational path from `out_ready` to `a1_out`, `b1_out` or `out_valid`.
- `busy` is registered and consistent with the state.

## Configuration
- `MDCLCG_SAMPLE_COUNT_EN` defined:
  - Includes the 32-bit accepted-pair counter.
  - The counter clears on `rst` and on `seed_load`.
- Not defined:
  - No counter logic.
  - `sample_count` is tied to 32'd0.
  - All other behaviour is identical.

## Test plan
- Reset then idle: hold `rst` for 2 cycles, then pulse `start` with no seed loaded. Outputs stay 0, `out_valid` = 0, state stays IDLE.
- Zero-seed first value: `seed_a` = 0, `seed_b` = 0, `seed_load`, then `start` with `out_ready` = 1. Two edges after `start`, `a1_out` = 1442695040888963407 and `b1_out` = 3037000493 with `out_valid` = 1.
- Unit seed: `seed_a` = 1, then `start`. The first `a1_out` = 7806831264735756412. A stream of 8 cycles with `out_ready` high matches the software model, and `sample_count` = 8.
- Backpressure: in RUN, drop `out_ready` for 5 cycles. `a1_out`/`b1_out` hold, `sample_count` holds, `out_valid` stays 1. On reassert, the sequence resumes with no skipped value.
- Stop/handshake collision: assert `stop` and `out_ready` in the same RUN cycle. The regs advance once, the count increments by 1, the state becomes SEEDED and `out_valid` goes to 0. After `start`, the next output equals two steps beyond the last accepted value.
- Reseed mid-run: `seed_load` with `seed_a` = 0 while in RUN and `out_ready` = 1. The next cycle shows `out_valid` = 0 and state SEEDED. `sample_count` = 0 when `MDCLCG_SAMPLE_COUNT_EN` is defined. A following `start` yields 1442695040888963407 again.
